stream_widener: RTL and testbench

Stream width converter that packs G_RATIO consecutive G_DATA_SIZE-bit input words into one output word of G_RATIO*G_DATA_SIZE bits, with an optional early flush on a last marker. It sits directly downstream of the one-stage buffer and consumes its valid/ready output stream, presenting a wide valid/ready stream to the next stage. Both sides use the same valid/ready handshake rules as the buffer.

---
 rtl/stream_widener.sv | 76 +++++++
 tb/tb_stream_widener.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_widener.sv
// Packs G_RATIO narrow input words into one wide output word, lane 0 first,
// closing early on s_last_i. Valid/ready on both sides.
module stream_widener #(
    parameter int G_DATA_SIZE = 8,
    parameter int G_RATIO     = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               s_valid_i,
    output logic                               s_ready_o,
    input  logic [G_DATA_SIZE-1:0]             s_data_i,
    input  logic                               s_last_i,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic [G_RATIO*G_DATA_SIZE-1:0]     m_data_o,
    output logic [$clog2(G_RATIO):0]           m_count_o,
    output logic                               m_last_o
);

    localparam int LW = $clog2(G_RATIO);
    localparam int CW = LW + 1;
    localparam int OW = G_RATIO * G_DATA_SIZE;

    logic [OW-1:0] data_q;
    logic [OW-1:0] next_data;
    logic [LW-1:0] lane_q;
    logic          accept;
    logic          consume;
    logic          closes;

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and a held word stays stable.
    assign s_ready_o = !rst_i && (!m_valid_o || m_ready_i);
    assign accept    = s_valid_i && s_ready_o;
    assign consume   = m_valid_o && m_ready_i;
    assign closes    = s_last_i || (lane_q == LW'(G_RATIO - 1));
    assign m_data_o  = data_q;

    // Writing lane 0 starts a fresh word, so every higher lane is cleared.
    always_comb begin
        next_data = (lane_q == '0) ? '0 : data_q;
        for (int k = 0; k < G_RATIO; k++) begin
            if (LW'(k) == lane_q) begin
                next_data[k*G_DATA_SIZE +: G_DATA_SIZE] = s_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= '0;
            lane_q    <= '0;
            m_valid_o <= 1'b0;
            m_count_o <= '0;
            m_last_o  <= 1'b0;
        end else begin
            if (consume) begin
                m_valid_o <= 1'b0;
                m_count_o <= '0;
                m_last_o  <= 1'b0;
            end
            if (accept) begin
                data_q <= next_data;
                if (closes) begin
                    m_valid_o <= 1'b1;
                    m_count_o <= {1'b0, lane_q} + CW'(1);
                    m_last_o  <= s_last_i;
                    lane_q    <= '0;
                end else begin
                    lane_q <= lane_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_widener.sv
// Self-checking bench for stream_widener: directed cases plus random traffic
// compared against a packet-level packing model.
module tb_stream_widener;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int OW = DW * R;
    localparam int CW = $clog2(R) + 1;
    localparam int EW = OW + CW + 1;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic [CW-1:0] m_count;
    logic          m_last;

    stream_widener #(.G_DATA_SIZE(DW), .G_RATIO(R)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .m_count_o (m_count),
        .m_last_o  (m_last)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: words in arrival order, packed R at a time or at last
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] acc[R];
    int            acc_n = 0;
    bit            pend_close = 0;
    bit            hold_v = 0;
    logic [OW-1:0] hold_data;
    logic [CW-1:0] hold_count;
    logic          hold_last;

    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        logic [OW-1:0] w;
        acc[acc_n] = d;
        acc_n++;
        if (acc_n == R || l) begin
            w = '0;
            for (int k = 0; k < acc_n; k++) w = w | (OW'(acc[k]) << (k * DW));
            exp_q.push_back({l, CW'(acc_n), w});
            acc_n = 0;
            pend_close = 1;
        end
    endtask

    task automatic model_reset();
        acc_n = 0;
        exp_q.delete();
        pend_close = 0;
        hold_v = 0;
    endtask

    // observe just before the edge that performs the handshakes
    task automatic monitor();
        logic [EW-1:0] e;
        check("s_ready", s_ready, !m_valid || m_ready);
        if (pend_close) check("latency_valid", m_valid, 1);
        pend_close = 0;
        if (hold_v) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, hold_data);
            check("hold_count", m_count, hold_count);
            check("hold_last", m_last, hold_last);
        end
        hold_v = 0;
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", m_valid, 0);
            end else if (m_ready) begin
                e = exp_q.pop_front();
                check("m_data", m_data, e[OW-1:0]);
                check("m_count", m_count, e[OW+CW-1:OW]);
                check("m_last", m_last, e[EW-1]);
            end
        end
        if (m_valid && !m_ready) begin
            hold_v     = 1;
            hold_data  = m_data;
            hold_count = m_count;
            hold_last  = m_last;
        end
        if (s_valid && s_ready) model_accept(s_data, s_last);
    endtask

    // driver
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = r;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        #12;
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_count", m_count, 0);
        check("rst_last", m_last, 0);
        check("rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", s_ready, 1);

        // full word back-to-back
        drive(1, 8'h11, 0, 1); step();
        drive(1, 8'h22, 0, 1); step();
        drive(1, 8'h33, 0, 1); step();
        drive(1, 8'h44, 0, 1); step();
        drive(0, 0, 0, 1);
        check("full_valid", m_valid, 1);
        check("full_data", m_data, 32'h44332211);
        check("full_count", m_count, 4);
        check("full_last", m_last, 0);
        step();
        check("full_one_cycle", m_valid, 0);

        // short packet closed by last
        drive(1, 8'hAA, 0, 1); step();
        drive(1, 8'hBB, 1, 1); step();
        drive(0, 0, 0, 1);
        check("part_data", m_data, 32'h0000BBAA);
        check("part_count", m_count, 2);
        check("part_last", m_last, 1);
        step();

        // backpressure with pending input
        for (int i = 0; i < R; i++) begin
            drive(1, 8'hC0 + 8'(i), 0, 0); step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h99, 0, 0);
            #1;
            check("stall_s_ready", s_ready, 0);
            step();
        end
        drive(1, 8'h99, 0, 1); step();
        drive(0, 0, 0, 1);
        check("stall_after_valid", m_valid, 0);
        check("stall_after_data", m_data, 32'h00000099);

        // close the 0x99 word, then a single-word packet while it is consumed
        drive(1, 8'hA1, 0, 1); step();
        drive(1, 8'hA2, 0, 1); step();
        drive(1, 8'hA3, 0, 1); step();
        drive(1, 8'h5A, 1, 1); step();
        drive(0, 0, 0, 1);
        check("single_valid", m_valid, 1);
        check("single_data", m_data, 32'h0000005A);
        check("single_count", m_count, 1);
        check("single_last", m_last, 1);
        step();

        // eight words streaming without bubbles
        for (int i = 1; i <= 8; i++) begin
            drive(1, 8'(i), 0, 1);
            #1;
            check("stream_s_ready", s_ready, 1);
            step();
            if (i == 4) check("stream_w0", m_data, 32'h04030201);
        end
        check("stream_w1", m_data, 32'h08070605);
        drive(0, 0, 0, 1); step();

        // reset mid-accumulation
        drive(1, 8'h01, 0, 1); step();
        drive(1, 8'h02, 0, 1); step();
        drive(0, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_data", m_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 8'h10, 0, 1); step();
        drive(1, 8'h20, 0, 1); step();
        drive(1, 8'h30, 0, 1); step();
        drive(1, 8'h40, 0, 1); step();
        drive(0, 0, 0, 1);
        check("after_rst_data", m_data, 32'h40302010);
        check("after_rst_count", m_count, 4);
        step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 6);
            step();
        end

        // drain: flush any partial word, then empty the output
        drive(1, 8'hEE, 1, 1); step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1); step();
        end
        check("drained", exp_q.size(), 0);
        check("idle_valid", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
